// File: rtl/sl3p_pkg.sv
// sl3p_pkg: block header codes, control type codes, lane widths and the
// control-payload layout shared by the 2-lane framer and deframer.
package sl3p_pkg;

  // 2-bit sync header in bits [65:64] of every lane block
  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  // Control block type codes (payload [63:56])
  localparam logic [7:0] CT_IDLE  = 8'h1E;
  localparam logic [7:0] CT_EOB   = 8'h87;
  localparam logic [7:0] CT_UCTRL = 8'h55;

  localparam int PAYLOAD_W = 64;
  localparam int BLOCK_W   = 66;
  localparam int UCTRL_W   = 48;
  localparam int KEEP_W    = 16;

  // Control payload: type, in-band flow control, type-specific field
  typedef struct packed {
    logic [7:0]         ctype;
    logic [7:0]         flow;
    logic [UCTRL_W-1:0] field;
  } ctrl_payload_t;

  // What the transmitter puts on the lanes in a given cycle
  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_EOB,
    SLOT_UCTRL,
    SLOT_DATA
  } tx_slot_t;

  // Build one complete control block for a single lane
  function automatic logic [BLOCK_W-1:0] ctrl_block(
    input logic [7:0]         ctype,
    input logic [7:0]         flow,
    input logic [UCTRL_W-1:0] field
  );
    ctrl_payload_t p;
    p.ctype = ctype;
    p.flow  = flow;
    p.field = field;
    return {HDR_CTRL, p};
  endfunction

  // True for the control types the receiver understands
  function automatic logic known_ctype(input logic [7:0] ctype);
    return (ctype == CT_IDLE) || (ctype == CT_EOB) || (ctype == CT_UCTRL);
  endfunction

endpackage

// File: rtl/sl3p_rx_deframer.sv
// sl3p_rx_deframer: parses aligned/deskewed 2-lane blocks back into a
// 128-bit stream. Each data beat is held one stage so the following block
// can decide whether it is the last beat of a burst (EOB) or not.
module sl3p_rx_deframer
  import sl3p_pkg::*;
(
  input  logic                     clk,
  input  logic                     sys_arst,
  input  logic [2*BLOCK_W-1:0]     lane_data,
  output logic [2*PAYLOAD_W-1:0]   rx_tdata,
  output logic [KEEP_W-1:0]        rx_tkeep,
  output logic                     rx_tvalid,
  output logic                     rx_tlast,
  output logic [7:0]               rx_flow_control,
  output logic [2*UCTRL_W-1:0]     rx_user_ctrl,
  output logic                     rx_user_ctrl_valid,
  output logic                     rx_hard_error
);

  logic [2*BLOCK_W-1:0]   lane_q;
  logic [1:0]             hdr0, hdr1;
  ctrl_payload_t          pay0, pay1;
  logic                   beat_err;
  logic                   is_data, is_ctrl, is_eob, is_uctrl;
  logic                   hold_vld;
  logic [2*PAYLOAD_W-1:0] hold_data;
  logic                   emit_vld, emit_last;
  logic [2*PAYLOAD_W-1:0] emit_data;
  logic [KEEP_W-1:0]      emit_keep;
  logic                   unused_lane1_flow;

  assign hdr0 = lane_q[BLOCK_W-1 -: 2];
  assign hdr1 = lane_q[2*BLOCK_W-1 -: 2];
  assign pay0 = lane_q[PAYLOAD_W-1:0];
  assign pay1 = lane_q[BLOCK_W+PAYLOAD_W-1:BLOCK_W];

  // Lane 1 flow is a copy of lane 0 and is deliberately not checked
  assign unused_lane1_flow = ^pay1.flow;

  // Input register; resets to IDLE so the parser starts quietly
  always_ff @(posedge clk or posedge sys_arst) begin
    if (sys_arst) begin
      lane_q <= {2{ctrl_block(CT_IDLE, 8'h00, {UCTRL_W{1'b0}})}};
    end else begin
      lane_q <= lane_data;
    end
  end

  // Classify the registered beat; any malformation marks the whole beat bad
  always_comb begin
    beat_err = 1'b0;
    if ((hdr0 != HDR_DATA && hdr0 != HDR_CTRL) || (hdr0 != hdr1)) begin
      beat_err = 1'b1;
    end else if (hdr0 == HDR_CTRL) begin
      if ((pay0.ctype != pay1.ctype) || !known_ctype(pay0.ctype)) begin
        beat_err = 1'b1;
      end
    end
    is_data  = !beat_err && (hdr0 == HDR_DATA);
    is_ctrl  = !beat_err && (hdr0 == HDR_CTRL);
    is_eob   = is_ctrl && (pay0.ctype == CT_EOB);
    is_uctrl = is_ctrl && (pay0.ctype == CT_UCTRL);
  end

  // Decide what leaves the hold stage: EOB closes the burst (or emits an
  // empty last beat), anything else releases the held beat as non-last
  always_comb begin
    emit_vld  = hold_vld;
    emit_last = 1'b0;
    emit_data = hold_data;
    emit_keep = {KEEP_W{1'b1}};
    if (is_eob) begin
      emit_vld  = 1'b1;
      emit_last = 1'b1;
      emit_keep = pay0.field[KEEP_W-1:0];
      emit_data = hold_vld ? hold_data : '0;
    end
  end

  // Hold stage, stream outputs and sideband updates
  always_ff @(posedge clk or posedge sys_arst) begin
    if (sys_arst) begin
      hold_vld           <= 1'b0;
      hold_data          <= '0;
      rx_tvalid          <= 1'b0;
      rx_tlast           <= 1'b0;
      rx_tdata           <= '0;
      rx_tkeep           <= '0;
      rx_flow_control    <= 8'h00;
      rx_user_ctrl       <= '0;
      rx_user_ctrl_valid <= 1'b0;
      rx_hard_error      <= 1'b0;
    end else begin
      rx_tvalid          <= emit_vld;
      rx_tlast           <= emit_vld & emit_last;
      rx_user_ctrl_valid <= is_uctrl;
      rx_hard_error      <= beat_err;
      if (emit_vld) begin
        rx_tdata <= emit_data;
        rx_tkeep <= emit_keep;
      end
      if (is_data) begin
        hold_vld  <= 1'b1;
        hold_data <= {pay1, pay0};
      end else begin
        hold_vld  <= 1'b0;
      end
      if (is_ctrl) begin
        rx_flow_control <= pay0.flow;
      end
      if (is_uctrl) begin
        rx_user_ctrl <= {pay1.field, pay0.field};
      end
    end
  end

endmodule

// File: rtl/sl3p_2ln_link.sv
// sl3p_2ln_link: two-lane link-layer framer/deframer. The TX framer turns a
// 128-bit stream plus flow-control and user-control words into 66-bit lane
// blocks; the RX side is sl3p_rx_deframer.
// Optional build macro SL3P_SLOOP_EN adds input 'sloop', which feeds the
// registered TX lanes into the RX parser instead of rx_lane_data.
module sl3p_2ln_link
  import sl3p_pkg::*;
#(
  parameter int LANES     = 2,   // fixed at 2
  parameter int FC_PERIOD = 64   // 2..255
) (
  input  logic                       clk,
  input  logic                       sys_arst,
`ifdef SL3P_SLOOP_EN
  input  logic                       sloop,
`endif
  input  logic [LANES*PAYLOAD_W-1:0] tx_tdata,
  input  logic [KEEP_W-1:0]          tx_tkeep,
  input  logic                       tx_tvalid,
  input  logic                       tx_tlast,
  output logic                       tx_tready,
  input  logic                       tx_halt,
  input  logic [7:0]                 tx_flow_control,
  input  logic [LANES*UCTRL_W-1:0]   tx_user_ctrl,
  input  logic                       tx_user_ctrl_req,
  output logic                       tx_user_ctrl_ack,
  output logic [LANES*BLOCK_W-1:0]   tx_lane_data,
  input  logic [LANES*BLOCK_W-1:0]   rx_lane_data,
  output logic [LANES*PAYLOAD_W-1:0] rx_tdata,
  output logic [KEEP_W-1:0]          rx_tkeep,
  output logic                       rx_tvalid,
  output logic                       rx_tlast,
  output logic [7:0]                 rx_flow_control,
  output logic [LANES*UCTRL_W-1:0]   rx_user_ctrl,
  output logic                       rx_user_ctrl_valid,
  output logic                       rx_hard_error
);

  // Down-counter of data slots left before a forced control slot
  localparam logic [7:0] FC_LOAD = 8'(FC_PERIOD - 1);

  logic                     eob_pend;
  logic [KEEP_W-1:0]        eob_keep;
  logic [7:0]               fc_cnt;
  logic                     fc_force;
  tx_slot_t                 slot;
  logic [LANES*BLOCK_W-1:0] lane_nxt;
  logic [LANES*BLOCK_W-1:0] tx_lane_q;
  logic [LANES*BLOCK_W-1:0] rx_src;

  assign fc_force  = (fc_cnt == 8'h00);
  assign tx_tready = ~eob_pend & ~tx_user_ctrl_req & ~tx_halt & ~fc_force;

  // Slot arbitration: pending EOB, then user control, then data, else IDLE
  always_comb begin
    slot = SLOT_IDLE;
    if (eob_pend) begin
      slot = SLOT_EOB;
    end else if (tx_user_ctrl_req) begin
      slot = SLOT_UCTRL;
    end else if (tx_tvalid && tx_tready) begin
      slot = SLOT_DATA;
    end
  end

  assign tx_user_ctrl_ack = (slot == SLOT_UCTRL);

  // Build both lane blocks for the chosen slot; lane 1 is the upper half
  always_comb begin
    lane_nxt = {2{ctrl_block(CT_IDLE, tx_flow_control, {UCTRL_W{1'b0}})}};
    case (slot)
      SLOT_EOB: begin
        lane_nxt = {ctrl_block(CT_EOB, tx_flow_control, {UCTRL_W{1'b0}}),
                    ctrl_block(CT_EOB, tx_flow_control,
                               {{(UCTRL_W-KEEP_W){1'b0}}, eob_keep})};
      end
      SLOT_UCTRL: begin
        lane_nxt = {ctrl_block(CT_UCTRL, tx_flow_control,
                               tx_user_ctrl[2*UCTRL_W-1:UCTRL_W]),
                    ctrl_block(CT_UCTRL, tx_flow_control,
                               tx_user_ctrl[UCTRL_W-1:0])};
      end
      SLOT_DATA: begin
        lane_nxt = {HDR_DATA, tx_tdata[2*PAYLOAD_W-1:PAYLOAD_W],
                    HDR_DATA, tx_tdata[PAYLOAD_W-1:0]};
      end
      default: begin
      end
    endcase
  end

  // TX state: output blocks, end-of-burst pending and forced-control counter
  always_ff @(posedge clk or posedge sys_arst) begin
    if (sys_arst) begin
      tx_lane_q <= {2{ctrl_block(CT_IDLE, 8'h00, {UCTRL_W{1'b0}})}};
      eob_pend  <= 1'b0;
      eob_keep  <= '0;
      fc_cnt    <= FC_LOAD;
    end else begin
      tx_lane_q <= lane_nxt;
      if (slot == SLOT_DATA) begin
        fc_cnt   <= fc_cnt - 8'h01;
        eob_pend <= tx_tlast;
        if (tx_tlast) begin
          eob_keep <= tx_tkeep;
        end
      end else begin
        // Every non-data slot is a control slot and restarts the run
        fc_cnt <= FC_LOAD;
        if (slot == SLOT_EOB) begin
          eob_pend <= 1'b0;
        end
      end
    end
  end

  assign tx_lane_data = tx_lane_q;

`ifdef SL3P_SLOOP_EN
  assign rx_src = sloop ? tx_lane_q : rx_lane_data;
`else
  assign rx_src = rx_lane_data;
`endif

  sl3p_rx_deframer u_rx (
    .clk                (clk),
    .sys_arst           (sys_arst),
    .lane_data          (rx_src),
    .rx_tdata           (rx_tdata),
    .rx_tkeep           (rx_tkeep),
    .rx_tvalid          (rx_tvalid),
    .rx_tlast           (rx_tlast),
    .rx_flow_control    (rx_flow_control),
    .rx_user_ctrl       (rx_user_ctrl),
    .rx_user_ctrl_valid (rx_user_ctrl_valid),
    .rx_hard_error      (rx_hard_error)
  );

endmodule

// File: tb/tb_sl3p_2ln_link.sv
// tb_sl3p_2ln_link: external-loopback bench for sl3p_2ln_link. Sent beats
// are queued as expected RX beats; a negedge monitor pops and compares them.
module tb_sl3p_2ln_link;

  logic         clk = 1'b0;
  logic         sys_arst;
  logic [127:0] tx_tdata;
  logic [15:0]  tx_tkeep;
  logic         tx_tvalid, tx_tlast, tx_tready, tx_halt;
  logic [7:0]   tx_flow_control;
  logic [95:0]  tx_user_ctrl;
  logic         tx_user_ctrl_req, tx_user_ctrl_ack;
  logic [131:0] tx_lane_data, rx_lane_data;
  logic [127:0] rx_tdata;
  logic [15:0]  rx_tkeep;
  logic         rx_tvalid, rx_tlast;
  logic [7:0]   rx_flow_control;
  logic [95:0]  rx_user_ctrl;
  logic         rx_user_ctrl_valid, rx_hard_error;

  logic         inj_en;
  logic [131:0] inj_val;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ack    = 0;
  int n_ucv    = 0;
  int n_herr   = 0;
  int run_len  = 0;
  int max_run  = 0;
  int n_fc_idle = 0;

  localparam logic [131:0] IDLE_RST = {2'b10, 8'h1E, 8'h00, 48'h0,
                                       2'b10, 8'h1E, 8'h00, 48'h0};

  always #5 clk = ~clk;

  assign rx_lane_data = inj_en ? inj_val : tx_lane_data;

  sl3p_2ln_link #(.LANES(2), .FC_PERIOD(64)) dut (
    .clk                (clk),
    .sys_arst           (sys_arst),
`ifdef SL3P_SLOOP_EN
    .sloop              (1'b0),
`endif
    .tx_tdata           (tx_tdata),
    .tx_tkeep           (tx_tkeep),
    .tx_tvalid          (tx_tvalid),
    .tx_tlast           (tx_tlast),
    .tx_tready          (tx_tready),
    .tx_halt            (tx_halt),
    .tx_flow_control    (tx_flow_control),
    .tx_user_ctrl       (tx_user_ctrl),
    .tx_user_ctrl_req   (tx_user_ctrl_req),
    .tx_user_ctrl_ack   (tx_user_ctrl_ack),
    .tx_lane_data       (tx_lane_data),
    .rx_lane_data       (rx_lane_data),
    .rx_tdata           (rx_tdata),
    .rx_tkeep           (rx_tkeep),
    .rx_tvalid          (rx_tvalid),
    .rx_tlast           (rx_tlast),
    .rx_flow_control    (rx_flow_control),
    .rx_user_ctrl       (rx_user_ctrl),
    .rx_user_ctrl_valid (rx_user_ctrl_valid),
    .rx_hard_error      (rx_hard_error)
  );

  // Scoreboard monitor and event counters, sampled on the falling edge
  always @(negedge clk) begin
    if (sys_arst === 1'b0) begin
      if (rx_tvalid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rx_beat unexpected: data=%h keep=%h last=%b, none required",
                   rx_tdata, rx_tkeep, rx_tlast);
        end else begin
          mon_e = exp_q.pop_front();
          if ({rx_tdata, rx_tkeep, rx_tlast} !== mon_e)
            $display("FAIL rx_beat: got data=%h keep=%h last=%b, exp data=%h keep=%h last=%b",
                     rx_tdata, rx_tkeep, rx_tlast, mon_e.d, mon_e.k, mon_e.l);
          else
            n_pass++;
        end
      end
      if (tx_user_ctrl_ack)   n_ack++;
      if (rx_user_ctrl_valid) n_ucv++;
      if (rx_hard_error)      n_herr++;
      if (tx_lane_data[65:64] == 2'b01) begin
        run_len++;
      end else begin
        if (run_len > max_run) max_run = run_len;
        if (run_len == 63 && tx_lane_data[63:56] == 8'h1E) n_fc_idle++;
        run_len = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance and queue the RX expectation
  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    beat_t b;
    int waited = 0;
    tx_tvalid = 1'b1;
    tx_tdata  = d;
    tx_tkeep  = k;
    tx_tlast  = l;
    @(negedge clk);
    while (!tx_tready && waited < 50) begin
      tick();
      waited++;
      @(negedge clk);
    end
    if (!tx_tready) begin
      n_checks++;
      $display("FAIL send_beat: tready=%b after %0d cycles, exp 1", tx_tready, waited);
    end else begin
      b.d = d;
      b.k = l ? k : 16'hFFFF;
      b.l = l;
      exp_q.push_back(b);
    end
    tick();
    tx_tvalid = 1'b0;
    tx_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    sys_arst = 1'b1;
    tx_tdata = '0; tx_tkeep = '0; tx_tvalid = 1'b0; tx_tlast = 1'b0;
    tx_halt = 1'b0; tx_flow_control = 8'h00; tx_user_ctrl = '0;
    tx_user_ctrl_req = 1'b0; inj_en = 1'b0; inj_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tx_lane_data !== IDLE_RST) $display("FAIL reset_lanes: got %h exp %h", tx_lane_data, IDLE_RST);
    else n_pass++;
    n_checks++;
    if (tx_tready !== 1'b1) $display("FAIL reset_tready: got %b exp 1", tx_tready);
    else n_pass++;
    n_checks++;
    if ({tx_user_ctrl_ack, rx_tvalid, rx_tlast, rx_user_ctrl_valid, rx_hard_error} !== 5'b0)
      $display("FAIL reset_pulses: got %b exp 00000",
               {tx_user_ctrl_ack, rx_tvalid, rx_tlast, rx_user_ctrl_valid, rx_hard_error});
    else n_pass++;
    n_checks++;
    if ({rx_tdata, rx_tkeep, rx_flow_control, rx_user_ctrl} !== '0)
      $display("FAIL reset_rx_regs: got flow=%h uctrl=%h data=%h keep=%h exp all 0",
               rx_flow_control, rx_user_ctrl, rx_tdata, rx_tkeep);
    else n_pass++;
    tick();
    sys_arst = 1'b0;
    tx_halt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_tready !== 1'b0) $display("FAIL halt_tready: got %b exp 0", tx_tready);
    else n_pass++;
    tick();
    tx_halt = 1'b0;
    tx_flow_control = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rx_flow_control !== 8'hA5) $display("FAIL idle_flow: got %h exp a5", rx_flow_control);
    else n_pass++;
    tick();
  endtask

  task automatic test_burst3();
    logic [127:0] d0, d1, d2;
    d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    d2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_beat(d0, 16'hFFFF, 1'b0);
    send_beat(d1, 16'hFFFF, 1'b0);
    send_beat(d2, 16'h00FF, 1'b1);
    @(negedge clk);
    n_checks++;
    if (tx_tready !== 1'b0) $display("FAIL burst3_eob_tready: got %b exp 0", tx_tready);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if (tx_tready !== 1'b1) $display("FAIL burst3_tready_back: got %b exp 1", tx_tready);
    else n_pass++;
    tick();
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL burst3_drain: %0d beats outstanding, exp 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_empty_last();
    beat_t b;
    repeat (2) tick();
    send_beat(128'h0, 16'h0000, 1'b1);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL keep0_drain: %0d beats outstanding, exp 0", exp_q.size());
    else n_pass++;
    repeat (2) tick();
    inj_en  = 1'b1;
    inj_val = {2'b10, 8'h87, 8'h5A, 48'h0, 2'b10, 8'h87, 8'h5A, 32'h0, 16'h0003};
    b.d = '0; b.k = 16'h0003; b.l = 1'b1;
    exp_q.push_back(b);
    tick();
    inj_en = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL lone_eob_drain: %0d beats outstanding, exp 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_fc_period();
    n_fc_idle = 0;
    max_run   = 0;
    run_len   = 0;
    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 0) tx_flow_control = 8'(8'h10 + i);
      send_beat({$urandom(), $urandom(), $urandom(), $urandom()},
                (i == 199) ? 16'h0FFF : 16'hFFFF, i == 199);
    end
    tx_flow_control = 8'h3C;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    repeat (4) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL fc_drain: %0d beats outstanding, exp 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (n_fc_idle !== 3) $display("FAIL fc_idle_count: got %0d exp 3", n_fc_idle);
    else n_pass++;
    n_checks++;
    if (max_run !== 63) $display("FAIL fc_max_run: got %0d exp 63", max_run);
    else n_pass++;
    n_checks++;
    if (rx_flow_control !== 8'h3C) $display("FAIL fc_flow: got %h exp 3c", rx_flow_control);
    else n_pass++;
  endtask

  task automatic test_user_ctrl();
    int a0, u0;
    logic [95:0]  v;
    logic [131:0] blk;
    a0 = n_ack; u0 = n_ucv;
    v  = {24{4'h1}};
    tx_user_ctrl = v;
    tx_user_ctrl_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx_user_ctrl_ack, tx_tready} !== 2'b10)
      $display("FAIL uctrl_ack_tready: got ack=%b tready=%b exp ack=1 tready=0", tx_user_ctrl_ack, tx_tready);
    else n_pass++;
    tick();
    tx_user_ctrl_req = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (n_ack - a0 !== 1) $display("FAIL uctrl_ack_count: got %0d exp 1", n_ack - a0);
    else n_pass++;
    n_checks++;
    if (n_ucv - u0 !== 1) $display("FAIL uctrl_valid_count: got %0d exp 1", n_ucv - u0);
    else n_pass++;
    n_checks++;
    if (rx_user_ctrl !== v) $display("FAIL uctrl_value: got %h exp %h", rx_user_ctrl, v);
    else n_pass++;
    a0 = n_ack; u0 = n_ucv;
    v  = 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    blk = {2'b10, 8'h55, 8'h3C, v[95:48], 2'b10, 8'h55, 8'h3C, v[47:0]};
    tx_user_ctrl = v;
    tx_user_ctrl_req = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (tx_lane_data !== blk) $display("FAIL uctrl_lanes: got %h exp %h", tx_lane_data, blk);
    else n_pass++;
    tick();
    tick();
    tx_user_ctrl_req = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (n_ack - a0 !== 3) $display("FAIL uctrl_held_acks: got %0d exp 3", n_ack - a0);
    else n_pass++;
    n_checks++;
    if (n_ucv - u0 !== 3) $display("FAIL uctrl_held_valids: got %0d exp 3", n_ucv - u0);
    else n_pass++;
    n_checks++;
    if (rx_user_ctrl !== v) $display("FAIL uctrl_held_value: got %h exp %h", rx_user_ctrl, v);
    else n_pass++;
  endtask

  task automatic test_hard_error();
    int h0;
    beat_t b;
    logic [127:0] dd;
    h0 = n_herr;
    dd = {$urandom(), $urandom(), $urandom(), $urandom()};
    inj_en  = 1'b1;
    inj_val = {2'b01, dd[127:64], 2'b01, dd[63:0]};
    b.d = dd; b.k = 16'hFFFF; b.l = 1'b0;
    exp_q.push_back(b);
    tick();
    inj_val = {2'b11, 64'h0, 2'b01, 64'h0};
    tick();
    inj_val = {2'b10, 8'h77, 8'h00, 48'h0, 2'b10, 8'h77, 8'h00, 48'h0};
    tick();
    inj_en = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (n_herr - h0 !== 2) $display("FAIL herr_count: got %0d exp 2", n_herr - h0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL herr_flush: %0d beats outstanding, exp 0", exp_q.size());
    else n_pass++;
    h0 = n_herr;
    send_beat({$urandom(), $urandom(), $urandom(), $urandom()}, 16'hFFFF, 1'b0);
    send_beat({$urandom(), $urandom(), $urandom(), $urandom()}, 16'hF00F, 1'b1);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL herr_recover_drain: %0d beats outstanding, exp 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (n_herr - h0 !== 0) $display("FAIL herr_after_recover: got %0d exp 0", n_herr - h0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_burst3();
    test_empty_last();
    test_fc_period();
    test_user_ctrl();
    test_hard_error();
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sl3p_2ln_link.md
Name: sl3p_2ln_link

Overview:
- Two-lane link-layer framer/deframer for the SerialLite-III-style 2-lane link.
- Transmit side: converts an AXI-stream (128-bit beats, byte keep, last) plus in-band flow-control and user-control words into per-lane 66-bit blocks (2-bit header + 64-bit payload).
- Receive side: parses already-aligned, deskewed lane blocks back into the stream.
- Sits between user logic and the PCS/transceiver lane interface; one clock domain.

Parameters:
- LANES, 2, lane count (fixed at 2; other values unsupported).
- FC_PERIOD, 64, maximum beats between forced control beats (carries flow control); range 2..255.

Ports:
- clk  in  1  link clock, all logic posedge.
- sys_arst  in  1  asynchronous active-high reset.
- tx_tdata  in  128  beat data; bits [63:0] to lane 0.
- tx_tkeep  in  16  byte enables, only meaningful with tx_tlast.
- tx_tvalid  in  1  beat valid.
- tx_tlast  in  1  final beat of burst.
- tx_tready  out  1  beat accepted when tvalid&tready.
- tx_halt  in  1  stop accepting data.
- tx_flow_control  in  8  in-band flow-control value.
- tx_user_ctrl  in  96  user control word, 48 bits per lane.
- tx_user_ctrl_req  in  1  request to send tx_user_ctrl.
- tx_user_ctrl_ack  out  1  one-cycle pulse when sent.
- tx_lane_data  out  132  lane i block at [66i+65:66i]; header at [66i+65:66i+64].
- rx_lane_data  in  132  received lane blocks, same layout.
- rx_tdata  out  128  received beat.
- rx_tkeep  out  16  received keep.
- rx_tvalid  out  1  received beat valid.
- rx_tlast  out  1  received last.
- rx_flow_control  out  8  last received flow-control value.
- rx_user_ctrl  out  96  last received user control.
- rx_user_ctrl_valid  out  1  one-cycle pulse on new rx_user_ctrl.
- rx_hard_error  out  1  one-cycle pulse on malformed beat.

Behaviour:
- Headers: 2'b01 = data, 2'b10 = control. Control payload: [63:56] type; [55:48] flow control; [47:0] field.
- Types: IDLE=8'h1E, EOB=8'h87 (lane 0 field[15:0] = keep), UCTRL=8'h55 (field = that lane's 48-bit user-ctrl slice).
- Both lanes always carry the same header and type.
- tx_tready = ~eob_pend & ~tx_user_ctrl_req & ~tx_halt & ~fc_force (combinational from registers and inputs).
- TX slot priority per cycle, tx_lane_data registered (1-cycle latency):
  1. EOB if eob_pend.
  2. Else UCTRL if tx_user_ctrl_req; pulse ack the same cycle.
  3. Else data if tvalid&tready.
  4. Else IDLE.
- Accepted beat with tlast sets eob_pend; the following slot is EOB carrying the latched tkeep.
- Beat counter counts consecutive data slots and clears on any control slot. When it reaches FC_PERIOD-1, fc_force is set, so the next slot is IDLE.
- Every control slot samples the current tx_flow_control.
- UCTRL held for multiple cycles re-sends every cycle with an ack each time.
- RX registers the lanes, then holds each data beat one stage:
  - If the next beat is EOB: output the held beat with tlast=1 and tkeep=EOB keep.
  - Else if the next beat is data or non-EOB control: output the held beat with tlast=0 and tkeep=16'hFFFF.
  - EOB with no held beat: output tvalid=1, tdata=0, tlast=1, tkeep=EOB keep (empty last beat).
  - RX latency: lane input to rx_tvalid is 2 cycles after the following beat arrives.
- Every valid control beat updates rx_flow_control from lane 0 [55:48]. UCTRL updates rx_user_ctrl and pulses rx_user_ctrl_valid.
- rx_hard_error: header 00/11, lanes with different headers or types, or unknown type. The offending beat is discarded and any held beat is flushed with tlast=0.
- Reset: tx_lane_data = IDLE on both lanes with flow 0. Outputs tx_user_ctrl_ack, rx_tvalid, rx_tlast, rx_user_ctrl_valid and rx_hard_error = 0. rx_tdata, rx_tkeep, rx_flow_control, rx_user_ctrl = 0. eob_pend, held beat and counter cleared.
- Reset mid-burst drops the partial burst with no tlast emitted.

Optional Feature:
- Macro SL3P_SLOOP_EN adds input port sloop (1 bit). When sloop=1, the RX parser takes the registered tx_lane_data instead of rx_lane_data; tx_lane_data still drives out.
- Without the macro: no port, and RX always uses rx_lane_data.

Decomposition:
- Package sl3p_pkg holds:
  - header constants HDR_DATA and HDR_CTRL;
  - type codes IDLE, EOB and UCTRL;
  - lane width constants 64/66/48;
  - a control-payload packed struct {type, flow, field}.
- Sub-module sl3p_rx_deframer implements the RX parse/hold/error path. The top holds the TX framer and loopback mux.

Test Plan:
- Reset then idle: tx_lane_data = {2'b10,8'h1E,8'h00,48'h0} per lane; with tx_flow_control=8'hA5 looped back, rx_flow_control=8'hA5 within 3 cycles.
- Loopback a 3-beat burst, last beat tkeep=16'h00FF -> rx emits the same 3 beats, tlast only on beat 3 with tkeep 16'h00FF; tx_tready low for 1 cycle after beat 3.
- Burst with tlast beat tkeep=0 directly after idle -> rx emits tvalid, tdata=0, tlast=1, tkeep=0.
- Continuous data for 200 beats with FC_PERIOD=64 -> an IDLE slot appears after every 63 data beats; flow-control changes propagate with no lost data.
- tx_user_ctrl=96'h1111…11, req held 1 cycle -> ack 1 pulse; rx_user_ctrl=96'h1111…11 with rx_user_ctrl_valid one pulse.
- Inject header 2'b11 on lane 1 -> rx_hard_error one pulse, beat dropped, subsequent beats received correctly.
